// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader's state encoding and the frame geometry live here.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs incoming bytes into little-endian 32-bit words and flags each
// completed word for one cycle, one cycle after its last byte arrives.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0] byte_cnt;

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shifting right puts the first byte received in the low lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= byte_valid && last_byte;
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        byte_cnt  <= byte_cnt + 2'd1;
        word_data <= {byte_data, word_data[31:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from a byte stream into instruction memory
// and keeps the CPU held in reset until a load ends with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 256,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(IMEM_DEPTH_WORDS + 1);

  loader_state_t    state, next_state;
  logic [15:0]      n_words;
  logic [15:0]      len_full;
  logic [7:0]       csum;
  logic [IDX_W-1:0] word_idx;
  logic             xfer;
  logic             start_ok;
  logic             asm_clear;
  logic             last_byte;
  logic             word_valid;
  logic [31:0]      word_data;

  assign xfer      = rx_valid && rx_ready;
  assign start_ok  = (state == IDLE) && start;
  assign asm_clear = xfer && (state == LEN_HI);
  assign len_full  = {rx_data, n_words[7:0]};

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (xfer && (state == DATA)),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // The write address follows the assembler's delayed strobe, so it always
  // names the word currently being written.
  assign imem_we    = word_valid;
  assign imem_wdata = word_data;
  assign imem_addr  = ADDR_W'({word_idx, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (len_full > 16'(IMEM_DEPTH_WORDS)) next_state = ERR;
          else if (len_full == 16'd0)           next_state = CHECK;
          else                                  next_state = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        // The previous word's write has always retired before this word's last byte.
        if (xfer && last_byte && (16'(word_idx) == n_words - 16'd1))
          next_state = CHECK;
      end
      CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = (rx_data == csum) ? DONE : ERR;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_words  <= '0;
      csum     <= '0;
      word_idx <= '0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      if (xfer && state == LEN_LO) n_words[7:0] <= rx_data;
      if (asm_clear) begin
        n_words[15:8] <= rx_data;
        csum          <= '0;
      end else if (xfer && state == DATA) begin
        csum <= csum ^ rx_data;
      end
      if (asm_clear)       word_idx <= '0;
      else if (word_valid) word_idx <= word_idx + 1'b1;
      if (start_ok)                error <= 1'b0;
      else if (next_state == ERR)  error <= 1'b1;
      if (start_ok)                cpu_hold <= 1'b1;
      else if (next_state == DONE) cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte while a
// scoreboard of expected memory writes is drained by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  wr_t        sb[$];
  logic [7:0] frame[$];

  imem_loader #(.IMEM_DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t exp_wr;
    if (done === 1'b1) done_cnt++;
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("write_expected", 32'(sb.size()), 32'd1);
      end else begin
        exp_wr = sb.pop_front();
        check_output("wr_addr", imem_addr, exp_wr.addr);
        check_output("wr_data", imem_wdata, exp_wr.data);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input int gap, input bit poke_start);
    int waited;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_output("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      start = (poke_start && i == 1);
    end
    start = 1'b0;
  endtask

  task automatic run_frame(input int gap, input bit poke, input int limit);
    logic [15:0] n;
    logic [31:0] word;
    int          nbytes;
    n      = {frame[1], frame[0]};
    word   = '0;
    nbytes = (limit < frame.size()) ? limit : frame.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (i >= 2 && n <= 16'd256 && i < 2 + 4 * int'(n)) begin
        word = {frame[i], word[31:8]};
        if ((i - 2) % 4 == 3) sb.push_back('{addr: 32'((i - 2) / 4 * 4), data: word});
      end
      apply_stimulus(frame[i], gap, poke && (i < nbytes - 1));
    end
  endtask

  function automatic bit frame_good();
    logic [7:0] x;
    int         n;
    n = int'({frame[1], frame[0]});
    x = '0;
    for (int i = 2; i < 2 + 4 * n; i++) x ^= frame[i];
    return x == frame[2 + 4 * n];
  endfunction

  task automatic settle_and_check(input string tag, input int done_before, input bit good);
    repeat (4) @(negedge clk);
    check_output({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check_output({tag, "_done"}, 32'(done_cnt - done_before), good ? 32'd1 : 32'd0);
    check_output({tag, "_error"}, 32'(error), good ? 32'd0 : 32'd1);
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), good ? 32'd0 : 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_output({tag, "_we"}, 32'(imem_we), 32'd0);
    check_output({tag, "_addr"}, imem_addr, 32'd0);
    check_output({tag, "_wdata"}, imem_wdata, 32'd0);
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    $display("[TB] two-word load");
    frame = '{8'h02, 8'h00, 8'hb3, 8'h03, 8'h53, 8'h00, 8'h33, 8'h85, 8'h84, 8'h40, 8'h91};
    d0 = done_cnt;
    run_frame(0, 1'b0, 100);
    settle_and_check("good", d0, frame_good());

    $display("[TB] bad checksum");
    frame[10] = 8'h90;
    d0 = done_cnt;
    run_frame(0, 1'b0, 100);
    settle_and_check("badsum", d0, frame_good());

    $display("[TB] empty program");
    frame = '{8'h00, 8'h00, 8'h00};
    d0 = done_cnt;
    run_frame(0, 1'b0, 100);
    settle_and_check("empty", d0, frame_good());

    $display("[TB] oversize length");
    frame = '{8'h01, 8'h01};
    d0 = done_cnt;
    run_frame(0, 1'b0, 100);
    check_output("oversize_error_now", 32'(error), 32'd1);
    check_output("oversize_busy_now", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_output("oversize_rx_ready", 32'(rx_ready), 32'd0);
    check_output("oversize_done", 32'(done_cnt - d0), 32'd0);
    check_output("oversize_cpu_hold", 32'(cpu_hold), 32'd1);

    $display("[TB] stalled load with stray start pulses");
    frame = '{8'h02, 8'h00, 8'hb3, 8'h03, 8'h53, 8'h00, 8'h33, 8'h85, 8'h84, 8'h40, 8'h91};
    d0 = done_cnt;
    run_frame(3, 1'b1, 100);
    settle_and_check("stall", d0, frame_good());

    $display("[TB] reset during payload");
    run_frame(0, 1'b0, 7);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    check_output("midreset_drained", 32'(sb.size()), 32'd0);
    d0 = done_cnt;
    run_frame(0, 1'b0, 100);
    settle_and_check("reload", d0, frame_good());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
